// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed access
// latency, valid/ready handshakes on both the request and response sides.
module dmem_resp #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = DATA_W / 8;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]     cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BW-1:0]     lat_wmask;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BW-1:0]     acc_wmask;
  logic [AW-1:0]     acc_idx;
  logic              acc_err;
  logic              accept;
  logic              enter_resp;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = (state == IDLE) && req_valid;

  // With LATENCY=1 the access happens on the accepting edge, so the request
  // fields must be taken straight from the inputs rather than the latches.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wmask = lat_wmask;
    end
  end

  always_comb begin
    acc_idx    = acc_addr[3 +: AW];
    acc_err    = (|acc_addr[2:0]) || (|acc_addr[ADDR_W-1:AW+3]);
    enter_resp = (accept && (LATENCY == 1)) ||
                 ((state == WAIT) && (cnt == CW'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (accept) begin
      cnt       <= CW'(LATENCY - 1);
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wmask <= req_wmask;
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= acc_err;
      resp_rdata <= (!acc_err && !acc_write) ? mem[acc_idx] : '0;
    end
  end

  // Store array has no reset; the rst_n gate keeps a request seen while in
  // reset from landing in memory.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && acc_write && !acc_err) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (acc_wmask[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: LATENCY=2 main instance plus a LATENCY=1 build.
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [7:0]  req_wmask;

  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [7:0]  b_req_wmask;

  dmem_resp #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_resp #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } txn_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [256];

  // Reference model: 2 KiB of 8-byte words, byte-lane merge on stores.
  task automatic model_push(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] m);
    exp_t        e;
    int unsigned idx;
    e.err   = (a % 8 != 0) || (a >= 64'd2048);
    e.rdata = '0;
    idx     = int'(a / 8) % 256;
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 8; b++)
          if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.rdata = ref_mem[idx];
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] m, output logic [63:0] rd, output logic er,
                         output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    resp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++;
    if (resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", resp_err); end
    checks++;
    if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_lat1 ready/valid got %b%b exp 10", b_req_ready, b_resp_valid);
    end
  endtask

  task automatic test_reset_midwait();
    logic [63:0] rd; logic er; int lat; exp_t e;
    model_push(1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF);
    run_txn(1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      errors++; $display("FAIL midwait_prestore got %h/%b exp %h/%b", rd, er, e.rdata, e.err);
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10;
    req_wdata = 64'hAAAAAAAAAAAAAAAA; req_wmask = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL midwait_in_wait ready/valid got %b%b exp 00", req_ready, resp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midwait_async_reset got %b exp 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL midwait_after_reset ready/valid got %b%b exp 10", req_ready, resp_valid);
    end
    model_push(1'b0, 64'h10, 64'h0, 8'h00);
    run_txn(1'b0, 64'h10, 64'h0, 8'h00, rd, er, lat);
    e = sb.pop_front();
    checks++;
    if (rd !== 64'h0123456789ABCDEF || rd !== e.rdata) begin
      errors++; $display("FAIL midwait_discarded got %h exp %h", rd, e.rdata);
    end
  endtask

  task automatic test_store_load();
    txn_t t[2];
    logic [63:0] rd; logic er; int lat; exp_t e;
    t[0] = '{1'b1, 64'h8, 64'h1122334455667788, 8'hFF};
    t[1] = '{1'b0, 64'h8, 64'h0, 8'h00};
    for (int i = 0; i < 2; i++) begin
      model_push(t[i].w, t[i].a, t[i].d, t[i].m);
      run_txn(t[i].w, t[i].a, t[i].d, t[i].m, rd, er, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL store_load[%0d] rdata got %h exp %h", i, rd, e.rdata); end
      checks++;
      if (er !== e.err) begin errors++; $display("FAIL store_load[%0d] err got %b exp %b", i, er, e.err); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL store_load[%0d] latency got %0d exp 2", i, lat); end
    end
    checks++;
    if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL store_load_value got %h exp 1122334455667788", rd); end
  endtask

  task automatic test_partial();
    txn_t t[4];
    logic [63:0] rd; logic er; int lat; exp_t e;
    t[0] = '{1'b1, 64'h8, 64'hFFFFFFFFFFFFFFFF, 8'h0F};
    t[1] = '{1'b0, 64'h8, 64'h0, 8'h00};
    t[2] = '{1'b1, 64'h8, 64'h5555555555555555, 8'h00};
    t[3] = '{1'b0, 64'h8, 64'h0, 8'h00};
    for (int i = 0; i < 4; i++) begin
      model_push(t[i].w, t[i].a, t[i].d, t[i].m);
      run_txn(t[i].w, t[i].a, t[i].d, t[i].m, rd, er, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        errors++; $display("FAIL partial[%0d] got %h/%b exp %h/%b", i, rd, er, e.rdata, e.err);
      end
      if (i % 2 == 1) begin
        checks++;
        if (rd !== 64'h11223344FFFFFFFF) begin errors++; $display("FAIL partial_merge[%0d] got %h exp 11223344ffffffff", i, rd); end
      end
    end
  endtask

  task automatic test_errors();
    txn_t t[6];
    logic [63:0] rd; logic er; int lat; exp_t e;
    t[0] = '{1'b1, 64'h0,   64'hA5A5A5A5A5A5A5A5, 8'hFF};
    t[1] = '{1'b0, 64'h4,   64'h0, 8'h00};
    t[2] = '{1'b1, 64'h800, 64'hDEADBEEFDEADBEEF, 8'hFF};
    t[3] = '{1'b1, 64'hC,   64'h7777777777777777, 8'hFF};
    t[4] = '{1'b0, 64'h0,   64'h0, 8'h00};
    t[5] = '{1'b0, 64'h8,   64'h0, 8'h00};
    for (int i = 0; i < 6; i++) begin
      model_push(t[i].w, t[i].a, t[i].d, t[i].m);
      run_txn(t[i].w, t[i].a, t[i].d, t[i].m, rd, er, lat);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL errors[%0d] rdata got %h exp %h", i, rd, e.rdata); end
      checks++;
      if (er !== e.err) begin errors++; $display("FAIL errors[%0d] err got %b exp %b", i, er, e.err); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat; exp_t e; int guard;
    model_push(1'b0, 64'h8, 64'h0, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h8; req_wmask = 8'h00;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", c, resp_valid); end
      checks++;
      if (resp_rdata !== e.rdata || resp_err !== e.err) begin
        errors++; $display("FAIL bp_data[%0d] got %h/%b exp %h/%b", c, resp_rdata, resp_err, e.rdata, e.err);
      end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b exp 0", c, req_ready); end
      if (c == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8;
        req_wdata = 64'h0; req_wmask = 8'hFF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release valid/ready got %b%b exp 01", resp_valid, req_ready);
    end
    model_push(1'b0, 64'h8, 64'h0, 8'h00);
    run_txn(1'b0, 64'h8, 64'h0, 8'h00, rd, er, lat);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || rd !== 64'h11223344FFFFFFFF) begin
      errors++; $display("FAIL bp_ignored_req got %h exp %h", rd, e.rdata);
    end
  endtask

  task automatic test_latency1();
    txn_t t[2];
    exp_t e;
    t[0] = '{1'b1, 64'h18, 64'hCAFEF00D12345678, 8'hFF};
    t[1] = '{1'b0, 64'h18, 64'h0, 8'h00};
    sb.push_back('{64'h0, 1'b0});
    sb.push_back('{64'hCAFEF00D12345678, 1'b0});
    b_resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (b_req_ready !== 1'b1) begin errors++; $display("FAIL lat1_idle[%0d] got %b exp 1", i, b_req_ready); end
      b_req_valid = 1'b1; b_req_write = t[i].w; b_req_addr = t[i].a;
      b_req_wdata = t[i].d; b_req_wmask = t[i].m;
      @(negedge clk);
      b_req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (b_resp_valid !== 1'b1 || b_req_ready !== 1'b0) begin
        errors++; $display("FAIL lat1_timing[%0d] valid/ready got %b%b exp 10", i, b_resp_valid, b_req_ready);
      end
      checks++;
      if (b_resp_rdata !== e.rdata || b_resp_err !== e.err) begin
        errors++; $display("FAIL lat1_data[%0d] got %h/%b exp %h/%b", i, b_resp_rdata, b_resp_err, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
    b_resp_ready = 1'b1;
    test_reset();
    test_reset_midwait();
    test_store_load();
    test_partial();
    test_errors();
    test_backpressure();
    test_latency1();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
